// File: rtl/core_pkg.sv
// Shared core definitions: load funct3 encodings, load-unit state,
// and the load legality check.
package core_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_WAIT,
        LD_DONE
    } ld_state_e;

    // High when the load type is illegal for the width or misaligned.
    function automatic logic ld_bad(
        input logic [2:0] f3,
        input logic [2:0] off,
        input logic       rv64
    );
        logic bad;
        bad = 1'b0;
        unique case (f3)
            F3_LB, F3_LBU: bad = 1'b0;
            F3_LH, F3_LHU: bad = off[0];
            F3_LW:         bad = off[1:0] != 2'b00;
            F3_LWU:        bad = !rv64 || off[1:0] != 2'b00;
            F3_LD:         bad = !rv64 || off != 3'b000;
            default:       bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Extracts and sign/zero-extends the byte, half, word or double
// selected by funct3 and the byte offset from a raw memory word.
module load_formatter
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN/8)
) (
    input  logic [XLEN-1:0]  RD,
    input  logic [2:0]       funct3,
    input  logic [OFF_W-1:0] addr_lo,
    output logic [XLEN-1:0]  fmt
);

    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;

    assign b = 8'(RD >> {addr_lo, 3'b000});
    assign h = 16'(RD >> {addr_lo[OFF_W-1:1], 4'b0000});

    generate
        if (XLEN == 64) begin : g_w64
            assign w = 32'(RD >> {addr_lo[OFF_W-1:2], 5'b00000});
        end else begin : g_w32
            assign w = 32'(RD);
        end
    endgenerate

    always_comb begin
        fmt = RD;
        case (funct3)
            F3_LB:   fmt = XLEN'($signed(b));
            F3_LBU:  fmt = XLEN'(b);
            F3_LH:   fmt = XLEN'($signed(h));
            F3_LHU:  fmt = XLEN'(h);
            F3_LW:   fmt = XLEN'($signed(w));
            F3_LWU:  fmt = XLEN'(w);
            default: fmt = RD;
        endcase
    end

endmodule

// File: rtl/load_data_reg.sv
// Memory-read data register: waits for mem_ready, formats the load
// and holds it; flags bad accesses and memory timeouts.
module load_data_reg
    import core_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15,
    parameter int OFF_W   = $clog2(XLEN/8)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [OFF_W-1:0] addr_lo,
    input  logic             clear,
    input  logic             mem_ready,
    input  logic [XLEN-1:0]  RD,
    output logic [XLEN-1:0]  data,
    output logic             valid,
    output logic             busy,
    output logic             fmt_err,
    output logic             timeout_err
);

    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

    ld_state_e        state;
    ld_state_e        nxt;
    logic [2:0]       f3_q;
    logic [OFF_W-1:0] off_q;
    logic [7:0]       cnt;
    logic [XLEN-1:0]  fmt;
    logic             bad;
    logic             go;
    logic             hit;
    logic             expire;

    assign bad    = ld_bad(funct3, 3'(addr_lo), XLEN == 64);
    assign go     = (state == LD_IDLE) && start;
    assign hit    = (state == LD_WAIT) && mem_ready;
    assign expire = (state == LD_WAIT) && !mem_ready && (cnt == TMAX);

    load_formatter #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_fmt (
        .RD      (RD),
        .funct3  (f3_q),
        .addr_lo (off_q),
        .fmt     (fmt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= LD_IDLE;
        end else if (clear) begin
            state <= LD_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            LD_IDLE: begin
                if (start) nxt = bad ? LD_DONE : LD_WAIT;
            end
            LD_WAIT: begin
                if (mem_ready || cnt == TMAX) nxt = LD_DONE;
            end
            LD_DONE: nxt = LD_IDLE;
            default: nxt = LD_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != LD_IDLE);
    end

    // Pulses are registered on entry to DONE, so they last exactly that cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f3_q        <= '0;
            off_q       <= '0;
            cnt         <= '0;
            data        <= '0;
            valid       <= 1'b0;
            fmt_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else if (clear) begin
            cnt         <= '0;
            data        <= '0;
            valid       <= 1'b0;
            fmt_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            valid       <= hit;
            fmt_err     <= go && bad;
            timeout_err <= expire;
            if (go) begin
                f3_q  <= funct3;
                off_q <= addr_lo;
                cnt   <= '0;
            end
            if (state == LD_WAIT && !mem_ready) cnt <= cnt + 8'd1;
            if (hit) data <= fmt;
        end
    end

endmodule

// File: tb/tb_load_data_reg.sv
// Bench for load_data_reg: RV32 and RV64 instances share one stimulus
// stream; vector table, corner sequences and a random run vs a model.
module tb_load_data_reg;

    localparam int TMO = 4;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  funct3;
    logic [2:0]  off;
    logic        clear;
    logic        mem_ready;
    logic [63:0] rd;

    logic [31:0] data32;
    logic        valid32, busy32, fe32, to32;
    logic [63:0] data64;
    logic        valid64, busy64, fe64, to64;

    int total;
    int nbad;
    logic [63:0] prev32;
    logic [63:0] prev64;

    load_data_reg #(.XLEN(32), .TIMEOUT(TMO)) d32 (
        .clk(clk), .reset_n(reset_n), .start(start), .funct3(funct3),
        .addr_lo(off[1:0]), .clear(clear), .mem_ready(mem_ready),
        .RD(rd[31:0]), .data(data32), .valid(valid32), .busy(busy32),
        .fmt_err(fe32), .timeout_err(to32)
    );

    load_data_reg #(.XLEN(64), .TIMEOUT(TMO)) d64 (
        .clk(clk), .reset_n(reset_n), .start(start), .funct3(funct3),
        .addr_lo(off), .clear(clear), .mem_ready(mem_ready),
        .RD(rd), .data(data64), .valid(valid64), .busy(busy64),
        .fmt_err(fe64), .timeout_err(to64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [2:0]  f3;
        logic [2:0]  off;
        logic [63:0] rd;
        int          d;
        int          k32;
        logic [63:0] v32;
        int          k64;
        logic [63:0] v64;
    } vec_t;

    vec_t tbl[17];

    // kind: 0 = data captured, 1 = format error, 2 = timeout
    function automatic void model(
        input int xl, input logic [2:0] f3, input int o_in,
        input logic [63:0] r, input int d,
        output int kind, output logic [63:0] val
    );
        int sz, o;
        logic [63:0] w, mask, raw;
        sz   = 1 << f3[1:0];
        o    = o_in % (xl / 8);
        w    = (xl == 32) ? {32'h0, r[31:0]} : r;
        mask = (sz == 8) ? '1 : ((64'd1 << (8 * sz)) - 64'd1);
        raw  = (w >> (8 * o)) & mask;
        if (!f3[2] && raw[8 * sz - 1]) raw = raw | ~mask;
        if (xl == 32) raw = {32'h0, raw[31:0]};
        val = raw;
        if (f3 == 3'd7 || (xl == 32 && (f3 == 3'd3 || f3 == 3'd6))
            || (o % sz) != 0) kind = 1;
        else if (d >= TMO) kind = 2;
        else kind = 0;
    endfunction

    function automatic int pulse_k(input int kind, input int d);
        if (kind == 1) return 1;
        if (kind == 2) return TMO + 1;
        return d + 2;
    endfunction

    function automatic logic [67:0] expv(
        input int k, input int pk, input int kind,
        input logic [63:0] v, input logic [63:0] p
    );
        logic [63:0] dv;
        dv = (kind == 0 && k >= pk) ? v : p;
        return {dv, k == pk && kind == 0, k <= pk,
                k == pk && kind == 1, k == pk && kind == 2};
    endfunction

    function automatic logic [67:0] got32();
        return {32'h0, data32, valid32, busy32, fe32, to32};
    endfunction

    function automatic logic [67:0] got64();
        return {data64, valid64, busy64, fe64, to64};
    endfunction

    task automatic chk(input string nm, input logic [67:0] got,
                       input logic [67:0] exp);
        total++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic txn(
        input string nm, input logic [2:0] f3, input logic [2:0] o,
        input logic [63:0] r, input int d, input bit hold,
        input int k32, input logic [63:0] v32,
        input int k64, input logic [63:0] v64
    );
        int p32, p64;
        p32 = pulse_k(k32, d);
        p64 = pulse_k(k64, d);
        @(negedge clk);
        start = 1'b1; funct3 = f3; off = o; rd = r; mem_ready = 1'b0;
        for (int k = 1; k <= TMO + 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk({nm, "/rv32"}, got32(), expv(k, p32, k32, v32, prev32));
            chk({nm, "/rv64"}, got64(), expv(k, p64, k64, v64, prev64));
            start = hold && (k <= d + 2);
            mem_ready = (d < TMO) && (k == d + 1);
        end
        start = 1'b0;
        mem_ready = 1'b0;
        if (k32 == 0) prev32 = v32;
        if (k64 == 0) prev64 = v64;
    endtask

    initial begin
        int k32, k64;
        logic [63:0] v32, v64, r;
        logic [2:0] f3, o;
        int d;
        total = 0; nbad = 0;
        prev32 = '0; prev64 = '0;
        reset_n = 1'b0; start = 1'b0; funct3 = '0; off = '0;
        clear = 1'b0; mem_ready = 1'b0; rd = '0;

        tbl[0]  = '{3'd2, 3'd0, 64'h0000_0000_DEAD_BEEF, 0,
                    0, 64'hDEAD_BEEF, 0, 64'hFFFF_FFFF_DEAD_BEEF};
        tbl[1]  = '{3'd0, 3'd3, 64'h0000_0000_8011_2233, 0,
                    0, 64'hFFFF_FF80, 0, 64'hFFFF_FFFF_FFFF_FF80};
        tbl[2]  = '{3'd4, 3'd3, 64'h0000_0000_8011_2233, 1,
                    0, 64'h0000_0080, 0, 64'h0000_0000_0000_0080};
        tbl[3]  = '{3'd1, 3'd2, 64'h0000_0000_8001_1234, 0,
                    0, 64'hFFFF_8001, 0, 64'hFFFF_FFFF_FFFF_8001};
        tbl[4]  = '{3'd5, 3'd2, 64'h0000_0000_8001_1234, 2,
                    0, 64'h0000_8001, 0, 64'h0000_0000_0000_8001};
        tbl[5]  = '{3'd2, 3'd0, 64'h0000_0000_1234_5678, 2,
                    0, 64'h1234_5678, 0, 64'h0000_0000_1234_5678};
        tbl[6]  = '{3'd2, 3'd2, 64'hAAAA_AAAA_AAAA_AAAA, 0,
                    1, 64'h0, 1, 64'h0};
        tbl[7]  = '{3'd3, 3'd0, 64'h8000_0000_0000_0001, 0,
                    1, 64'h0, 0, 64'h8000_0000_0000_0001};
        tbl[8]  = '{3'd6, 3'd4, 64'hF000_0000_0000_0000, 0,
                    1, 64'h0, 0, 64'h0000_0000_F000_0000};
        tbl[9]  = '{3'd2, 3'd4, 64'hF000_0000_0000_0000, 1,
                    0, 64'h0, 0, 64'hFFFF_FFFF_F000_0000};
        tbl[10] = '{3'd7, 3'd0, 64'h1111_2222_3333_4444, 0,
                    1, 64'h0, 1, 64'h0};
        tbl[11] = '{3'd1, 3'd1, 64'h1111_2222_3333_4444, 0,
                    1, 64'h0, 1, 64'h0};
        tbl[12] = '{3'd3, 3'd4, 64'h1111_2222_3333_4444, 0,
                    1, 64'h0, 1, 64'h0};
        tbl[13] = '{3'd0, 3'd5, 64'h0000_7F00_0000_0000, 1,
                    0, 64'h0, 0, 64'h0000_0000_0000_007F};
        tbl[14] = '{3'd5, 3'd6, 64'hBEEF_0000_0000_0000, 3,
                    0, 64'h0, 0, 64'h0000_0000_0000_BEEF};
        tbl[15] = '{3'd1, 3'd0, 64'h0000_0000_0000_C3A5, 3,
                    0, 64'hFFFF_C3A5, 0, 64'hFFFF_FFFF_FFFF_C3A5};
        tbl[16] = '{3'd2, 3'd0, 64'h5555_6666_7777_8888, 9,
                    2, 64'h0, 2, 64'h0};

        #1;
        chk("reset/rv32", got32(), 68'h0);
        chk("reset/rv64", got64(), 68'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 17; i++)
            txn($sformatf("vec%0d", i), tbl[i].f3, tbl[i].off, tbl[i].rd,
                tbl[i].d, 1'b0, tbl[i].k32, tbl[i].v32,
                tbl[i].k64, tbl[i].v64);

        // mem_ready while idle after a timeout must not capture
        @(negedge clk);
        rd = 64'h0BAD_0BAD_0BAD_0BAD; mem_ready = 1'b1; funct3 = 3'd2;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("idle_ready/rv32", got32(), {prev32, 4'b0000});
            chk("idle_ready/rv64", got64(), {prev64, 4'b0000});
        end
        mem_ready = 1'b0;

        // start held high through WAIT and DONE: one transaction only
        txn("hold_start", 3'd2, 3'd0, 64'hCAFE_F00D_A5A5_A5A5, 1, 1'b1,
            0, 64'hA5A5_A5A5, 0, 64'hFFFF_FFFF_A5A5_A5A5);

        // clear in the same cycle as mem_ready discards the data
        @(negedge clk);
        start = 1'b1; funct3 = 3'd2; off = 3'd0; rd = 64'h7777_7777_7777_7777;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("clr_wait/rv32", got32(), {prev32, 4'b0100});
        chk("clr_wait/rv64", got64(), {prev64, 4'b0100});
        mem_ready = 1'b1; clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b0; clear = 1'b0;
        chk("clr_hit/rv32", got32(), 68'h0);
        chk("clr_hit/rv64", got64(), 68'h0);
        @(posedge clk);
        @(negedge clk);
        chk("clr_after/rv32", got32(), 68'h0);
        chk("clr_after/rv64", got64(), 68'h0);
        prev32 = '0; prev64 = '0;

        for (int n = 0; n < 150; n++) begin
            f3 = 3'($urandom_range(0, 7));
            o  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) o = 3'($urandom_range(0, 1) * 4);
            r  = {$urandom(), $urandom()};
            d  = $urandom_range(0, TMO + 1);
            model(32, f3, int'(o), r, d, k32, v32);
            model(64, f3, int'(o), r, d, k64, v64);
            txn($sformatf("rnd%0d", n), f3, o, r, d, 1'b0, k32, v32, k64, v64);
        end

        // async reset while waiting: everything drops at once, no pulse
        txn("pre_rst", 3'd4, 3'd1, 64'h0000_0000_0000_9A00, 0, 1'b0,
            0, 64'h9A, 0, 64'h9A);
        @(negedge clk);
        start = 1'b1; funct3 = 3'd2; off = 3'd0; rd = 64'h1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("rst_wait/rv32", got32(), {prev32, 4'b0100});
        chk("rst_wait/rv64", got64(), {prev64, 4'b0100});
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid/rv32", got32(), 68'h0);
        chk("rst_mid/rv64", got64(), 68'h0);
        mem_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_after/rv32", got32(), 68'h0);
        chk("rst_after/rv64", got64(), 68'h0);

        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end

endmodule

// File: doc/load_data_reg.md
Name: load_data_reg

Overview:
- Parametrised memory-read data register for the multi-cycle RV core.
- Sits between data memory RD and the writeback mux; the control FSM pulses start in its MemRead state.
- Waits for a variable-latency memory's mem_ready, extracts and extends the byte/half/word/double selected by funct3 and the address offset, and holds the result until the next capture.
- Flags misaligned or illegal accesses and memory timeouts instead of capturing garbage.

Parameters:
- XLEN, 32, data width; legal values 32 or 64.
- TIMEOUT, 15, maximum WAIT cycles before abort; legal range 1..255.
- OFF_W, $clog2(XLEN/8), byte-offset width (derived; do not override).

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  load request pulse; sampled only in IDLE.
- funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
- addr_lo  in  OFF_W  byte offset of the load address.
- clear  in  1  synchronous flush.
- mem_ready  in  1  memory read data valid on RD this cycle.
- RD  in  XLEN  raw memory read word.
- data  out  XLEN  formatted load result, held between captures.
- valid  out  1  one-cycle pulse: data freshly updated.
- busy  out  1  high in WAIT and DONE.
- fmt_err  out  1  one-cycle pulse: misaligned or illegal funct3.
- timeout_err  out  1  one-cycle pulse: mem_ready never arrived.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset_n=0, immediate): state=IDLE, data=0, valid=0, fmt_err=0, timeout_err=0, counter=0.
- States: IDLE, WAIT, DONE (registered, binary encoded).
- IDLE with start=1: latch funct3 and addr_lo.
  - Illegal funct3 → DONE with fmt_err pending. Illegal means 011/110 when XLEN=32, or 111 always.
  - Misaligned → DONE with fmt_err pending. Misaligned means: half with addr_lo[0]=1; word with addr_lo[1:0]≠0; double with addr_lo≠0.
  - Otherwise → WAIT with counter cleared.
- WAIT:
  - mem_ready=1 → data <= format(RD), go to DONE with valid pending. mem_ready is legal in the first WAIT cycle.
  - Else counter++. The cycle in which counter reaches TIMEOUT-1 without mem_ready → DONE with timeout_err pending; data unchanged.
- DONE: exactly one of valid / fmt_err / timeout_err is high for this single cycle → IDLE.
- start outside IDLE is ignored (no queueing). mem_ready outside WAIT is ignored.
- Minimum latency: start at edge N, mem_ready high in cycle N+1, data updated at edge N+2, valid high in cycle N+2..N+3.
- busy = (state≠IDLE), combinational from state.
- Formatting (combinational, on the latched funct3/addr_lo):
  - Byte = RD[8*addr_lo +: 8].
  - Half = RD[16*addr_lo[OFF_W-1:1] +: 16].
  - Word = RD[32*addr_lo[OFF_W-1:2] +: 32] when XLEN=64, else RD.
  - Signed loads replicate the MSB to XLEN; unsigned loads zero-fill.
- Errors never modify data.
- clear (synchronous, highest priority after reset): state=IDLE, all pulses 0, counter=0, data=0; an in-flight mem_ready in the same cycle is discarded.
- Async reset mid-WAIT aborts silently; no pulse is emitted.

Decomposition:
- Shared package core_pkg:
  - funct3 load constants (F3_LB … F3_LWU).
  - load-state enum {LD_IDLE, LD_WAIT, LD_DONE}.
- Sub-module load_formatter: purely combinational; inputs RD, funct3, addr_lo; parameter XLEN; output formatted word.
  - Reused later by the store/AMO path; verified standalone.

Test Plan:
- LW, XLEN=32, addr_lo=0, RD=0xDEADBEEF, mem_ready one cycle after start → data=0xDEADBEEF at start+2, valid one cycle, busy cycles start+1..start+2.
- LB addr_lo=3, RD=0x80112233 → data=0xFFFFFF80. LBU same → 0x00000080. LH addr_lo=2, RD=0x8001_1234 → 0xFFFF8001. LHU addr_lo=2 → 0x00008001.
- LW with addr_lo=2, previous data=0x12345678 → fmt_err pulse at start+1, no WAIT, data stays 0x12345678. funct3=011 at XLEN=32 → fmt_err.
- TIMEOUT=4, mem_ready held 0 → timeout_err exactly 4 WAIT cycles after entry, then IDLE; a later mem_ready=1 in IDLE leaves data unchanged.
- XLEN=64: LD addr_lo=0, RD=0x8000_0000_0000_0001 → data identical. LWU addr_lo=4, RD=0xF0000000_00000000 → 0x00000000_F0000000. LW same → 0xFFFFFFFF_F0000000.
- Corner cases:
  - start held high across WAIT → no second transaction.
  - clear asserted in the same cycle as mem_ready → data=0, no valid.
  - reset_n low mid-WAIT → outputs 0 immediately.
